// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings the system PLL up from the 50 MHz reference
// clock. It pulses the PLL reset, waits for lock and qualifies that lock for a
// stable interval before it releases core reset. Lost lock or a restart
// request runs the sequence again. Failed attempts are bounded by a retry
// limit, and exhausting it raises a sticky failure flag.
`timescale 1ns/1ps

module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       req_restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_fail,
    output logic [2:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

    state_t           state_q;
    state_t           state_d;
    logic             sync1;
    logic             locked_s;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       retry_d;
    logic [7:0]       lost_d;
    logic             entry;
    logic             counting;

    assign state = state_q;

    // Two-flop synchronizer that brings the asynchronous PLL lock into the refclk domain
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    // Next-state and counter-update decode. A restart request takes priority over every state transition
    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        lost_d  = lost_cnt;
        if (req_restart) begin
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            retry_d = retry_cnt + 8'd1;
                            state_d = ST_RESET;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s)                state_d = ST_WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        if (lost_cnt != 8'hFF) lost_d = lost_cnt + 8'd1;
                        state_d = ST_RESET;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
        // A restart while already in RESET still counts as a fresh entry, so the PLL reset pulse starts again
        entry    = req_restart || (state_d != state_q);
        counting = (state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    end

    // State, counters and outputs. Outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            lost_cnt  <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            lock_fail <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_cnt <= retry_d;
            lost_cnt  <= lost_d;
            if (entry)         cnt <= '0;
            else if (counting) cnt <= cnt + CNT_ONE;
            pll_rst   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            sys_rst_n <= (state_d == ST_RUN);
            if (req_restart)             lock_fail <= 1'b0;
            else if (state_d == ST_FAIL) lock_fail <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters.
// A behavioural model pushes the expected outputs after every clock edge, and
// the falling-edge monitor pops and compares them. Directed sequences check
// the latencies, retry exhaustion, restart priority and asynchronous reset.
`timescale 1ns/1ps

module tb_pll_reset_sequencer;

    localparam int RST_C  = 4;
    localparam int TO_C   = 20;
    localparam int STAB_C = 8;
    localparam int MAXR   = 2;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       req_restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_fail;
    logic [2:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] lost_cnt;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .STABLE_CYCLES(STAB_C),
        .MAX_RETRIES  (MAXR),
        .CNT_W        (16)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .req_restart(req_restart),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_fail  (lock_fail),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    typedef struct packed {
        logic [2:0] st;
        logic       prst;
        logic       srst_n;
        logic       fail;
        logic [7:0] retry;
        logic [7:0] lost;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Behavioural model written from the state description: states 0..4, int counters
    int m_state = 0;
    int m_cnt   = 0;
    int m_retry = 0;
    int m_lost  = 0;
    bit m_fail  = 1'b0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    task automatic push_exp();
        exp_t e;
        e.st     = 3'(m_state);
        e.prst   = (m_state == 0) || (m_state == 4);
        e.srst_n = (m_state == 3);
        e.fail   = m_fail;
        e.retry  = 8'(m_retry);
        e.lost   = 8'(m_lost);
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        bit ls;
        int nxt;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        nxt  = m_state;
        if (req_restart) begin
            nxt     = 0;
            m_retry = 0;
            m_fail  = 1'b0;
        end else begin
            case (m_state)
                0: if (m_cnt == RST_C - 1) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (m_cnt == TO_C - 1) begin
                        if (m_retry == MAXR) nxt = 4;
                        else begin
                            m_retry = m_retry + 1;
                            nxt = 0;
                        end
                    end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (m_cnt == STAB_C - 1) nxt = 3;
                end
                3: begin
                    if (!ls) begin
                        if (m_lost < 255) m_lost = m_lost + 1;
                        nxt = 0;
                    end
                end
                default: nxt = m_state;
            endcase
        end
        if (nxt == 3 && m_state != 3) m_retry = 0;
        if (nxt == 4) m_fail = 1'b1;
        if (req_restart || nxt != m_state) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        m_state = nxt;
        push_exp();
    endtask

    initial begin
        forever begin
            @(posedge refclk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_cnt = 0; m_retry = 0; m_lost = 0;
                m_fail = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
                exp_q.delete();
                push_exp();
            end else begin
                model_step();
            end
        end
    end

    // Scoreboard monitor: compares the DUT against the oldest expected entry on the falling edge
    initial begin
        forever begin
            @(negedge refclk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_state",     32'(state),     32'(mon_e.st));
                check("sb_pll_rst",   32'(pll_rst),   32'(mon_e.prst));
                check("sb_sys_rst_n", 32'(sys_rst_n), 32'(mon_e.srst_n));
                check("sb_lock_fail", 32'(lock_fail), 32'(mon_e.fail));
                check("sb_retry_cnt", 32'(retry_cnt), 32'(mon_e.retry));
                check("sb_lost_cnt",  32'(lost_cnt),  32'(mon_e.lost));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #2;
    endtask

    task automatic wait_model(input int s, input int budget, input string tag);
        int i;
        i = 0;
        while (m_state != s && i < budget) begin
            tick();
            i++;
        end
        if (m_state != s) check(tag, 32'(m_state), 32'(s));
    endtask

    task automatic wait_stable_cnt(input int c, input int budget, input string tag);
        int i;
        i = 0;
        while (!(m_state == 2 && m_cnt == c) && i < budget) begin
            tick();
            i++;
        end
        if (!(m_state == 2 && m_cnt == c)) check(tag, 32'(m_cnt), 32'(c));
    endtask

    int edges;
    int n_st;
    int falls;
    int hi;
    int n;
    bit done;
    bit seen_wait;
    bit prev;

    initial begin
        rst_n       = 1'b0;
        pll_locked  = 1'b0;
        req_restart = 1'b0;
        repeat (3) @(posedge refclk);
        #2;
        check("rst_state",     32'(state),     32'd0);
        check("rst_pll_rst",   32'(pll_rst),   32'd1);
        check("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("rst_lock_fail", 32'(lock_fail), 32'd0);
        check("rst_retry",     32'(retry_cnt), 32'd0);
        check("rst_lost",      32'(lost_cnt),  32'd0);

        // Normal bring-up
        rst_n = 1'b1;
        wait_model(1, 20, "reach_wait_lock");
        repeat (5) tick();
        pll_locked = 1'b1;
        edges = 0; done = 1'b0;
        while (!done && edges < 50) begin
            @(posedge refclk); edges++; #1;
            if (sys_rst_n) done = 1'b1;
        end
        #1;
        check("lock_to_release_edges", 32'(edges), 32'd11);
        check("bringup_state", 32'(state), 32'd3);
        check("bringup_retry", 32'(retry_cnt), 32'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        edges = 0; done = 1'b0;
        while (!done && edges < 20) begin
            @(posedge refclk); edges++; #1;
            if (!sys_rst_n) done = 1'b1;
        end
        #1;
        check("loss_latency_edges", 32'(edges), 32'd3);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_lost_cnt", 32'(lost_cnt), 32'd1);

        // One-cycle glitch in STABLE at cnt 5
        pll_locked = 1'b1;
        wait_stable_cnt(5, 40, "reach_stable5");
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n_st = 0; seen_wait = 1'b0; n = 0;
        while (n < 60) begin
            @(posedge refclk); #1; n++;
            if (state == 3'd3) break;
            if (state == 3'd2) n_st++;
            else n_st = 0;
            if (state == 3'd1 && !seen_wait) begin
                seen_wait = 1'b1;
                check("glitch_retry", 32'(retry_cnt), 32'd0);
                check("glitch_sys_rst_n", 32'(sys_rst_n), 32'd0);
            end
        end
        #1;
        check("glitch_seen_wait", 32'(seen_wait), 32'd1);
        check("fresh_stable_len", 32'(n_st), 32'd8);
        check("glitch_run_state", 32'(state), 32'd3);

        // Remaining losses to 300 total, lost_cnt saturates
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b0;
            wait_model(0, 10, "loss_to_reset");
            pll_locked = 1'b1;
            wait_model(3, 40, "relock_run");
        end
        check("lost_saturated", 32'(lost_cnt), 32'd255);

        // Timeout exhaustion
        pll_locked = 1'b0;
        prev = pll_rst; hi = 0; falls = 0; n = 0;
        while (!lock_fail && n < 200) begin
            @(posedge refclk); #1; n++;
            if (pll_rst) hi++;
            else begin
                if (prev) begin
                    falls++;
                    check("rst_pulse_len", 32'(hi), 32'd4);
                end
                hi = 0;
            end
            prev = pll_rst;
        end
        #1;
        check("exhaust_pulses", 32'(falls), 32'd3);
        check("exhaust_state", 32'(state), 32'd4);
        check("exhaust_lock_fail", 32'(lock_fail), 32'd1);
        check("exhaust_pll_rst", 32'(pll_rst), 32'd1);
        check("exhaust_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("exhaust_retry", 32'(retry_cnt), 32'd2);
        repeat (5) tick();
        check("fail_hold_state", 32'(state), 32'd4);
        check("fail_hold_pll_rst", 32'(pll_rst), 32'd1);

        // Restart from FAIL
        req_restart = 1'b1;
        @(posedge refclk); #1;
        req_restart = 1'b0;
        check("restart_fail_state", 32'(state), 32'd0);
        check("restart_fail_pll_rst", 32'(pll_rst), 32'd1);
        check("restart_fail_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("restart_fail_lock_fail", 32'(lock_fail), 32'd0);
        check("restart_fail_retry", 32'(retry_cnt), 32'd0);
        check("restart_fail_lost", 32'(lost_cnt), 32'd255);
        #1;

        // Restart mid-STABLE
        pll_locked = 1'b1;
        wait_stable_cnt(3, 40, "reach_stable3");
        req_restart = 1'b1;
        @(posedge refclk); #1;
        req_restart = 1'b0;
        check("restart_stable_state", 32'(state), 32'd0);
        check("restart_stable_pll_rst", 32'(pll_rst), 32'd1);
        check("restart_stable_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("restart_stable_retry", 32'(retry_cnt), 32'd0);
        check("restart_stable_lost", 32'(lost_cnt), 32'd255);
        #1;

        // Asynchronous reset between edges while in RUN
        wait_model(3, 60, "final_run");
        #1;
        rst_n = 1'b0;
        #1;
        check("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("async_pll_rst", 32'(pll_rst), 32'd1);
        check("async_state", 32'(state), 32'd0);
        check("async_lock_fail", 32'(lock_fail), 32'd0);
        check("async_retry", 32'(retry_cnt), 32'd0);
        check("async_lost", 32'(lost_cnt), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_model(3, 60, "post_reset_run");
        check("post_reset_lost", 32'(lost_cnt), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
